// File: rtl/sp_offset_sequencer.sv
// Self-sequencing microcode for ADD SP,s8 (mode 0) and LD HL,SP+s8 (mode 1).
// Optional stall input i_Wait is present when SP_OFFSET_WAIT_EN is defined.
module sp_offset_sequencer #(
    parameter int unsigned STEPS      = 4,
    parameter int unsigned SP_W       = 16,
    parameter int unsigned WRITE_STEP = 1
) (
    input  logic            i_Clk,
    input  logic            i_Reset,
    input  logic            i_Start,
    input  logic            i_Mode,
    input  logic [SP_W-1:0] i_SP,
    input  logic [7:0]      i_Data,
`ifdef SP_OFFSET_WAIT_EN
    input  logic            i_Wait,
`endif
    output logic            o_Busy,
    output logic [STEPS-1:0] o_Step,
    output logic [3:0]      o_Cycle,
    output logic            o_Address_Out,
    output logic            o_Inc_PC,
    output logic            o_Bus_In,
    output logic [SP_W-1:0] o_Result,
    output logic            o_Write_SP,
    output logic            o_Write_HL,
    output logic [3:0]      o_Flags,
    output logic            o_Flag_Write,
    output logic            o_IR_Fetch,
    output logic            o_Done
);

    localparam int unsigned EXT_W = SP_W - 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_ADD   = 3'd3;
    localparam logic [2:0] S_FETCH = 3'd4;

    logic [2:0]       state_q, next_state;
    logic [STEPS-1:0] step_q, next_step;
    logic             mode_q, next_mode;
    logic [7:0]       imm_q;
    logic             hold_c;
    logic             last_step_c;
    logic             suppress_c;

    logic             busy_d, addr_d, bus_in_d, wsp_d, whl_d, fw_d, irf_d, done_d;
    logic [3:0]       cycle_d;

`ifdef SP_OFFSET_WAIT_EN
    assign hold_c = i_Wait;
`else
    assign hold_c = 1'b0;
`endif

    assign last_step_c = step_q[STEPS-1];
    assign suppress_c  = hold_c && (state_q != S_IDLE);
    assign o_Step      = step_q;

    // Next-state and registered-strobe decode
    always_comb begin
        next_state = state_q;
        next_step  = step_q;
        next_mode  = mode_q;
        busy_d     = 1'b0;
        cycle_d    = 4'b0000;
        addr_d     = 1'b0;
        bus_in_d   = 1'b0;
        wsp_d      = 1'b0;
        whl_d      = 1'b0;
        fw_d       = 1'b0;
        irf_d      = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_Start) begin
                    next_state = S_ADDR;
                    next_step  = STEPS'(1);
                    next_mode  = i_Mode;
                end
            end
            S_ADDR, S_DATA, S_ADD, S_FETCH: begin
                if (!hold_c) begin
                    next_step = last_step_c ? STEPS'(1) : (step_q << 1);
                    if (last_step_c) begin
                        case (state_q)
                            S_ADDR:  next_state = S_DATA;
                            S_DATA:  next_state = S_ADD;
                            S_ADD:   next_state = mode_q ? S_IDLE : S_FETCH;
                            default: next_state = S_IDLE;
                        endcase
                        if (next_state == S_IDLE) begin
                            next_step = '0;
                        end
                    end
                end
            end
            default: begin
                next_state = S_IDLE;
                next_step  = '0;
            end
        endcase

        busy_d = (next_state != S_IDLE);
        case (next_state)
            S_ADDR:  cycle_d = 4'b0001;
            S_DATA:  cycle_d = 4'b0010;
            S_ADD:   cycle_d = 4'b0100;
            S_FETCH: cycle_d = 4'b1000;
            default: cycle_d = 4'b0000;
        endcase

        // A frozen step keeps its strobes from its first occurrence only
        if (!suppress_c) begin
            addr_d   = (next_state == S_ADDR) && next_step[WRITE_STEP];
            bus_in_d = (next_state == S_DATA) && next_step[0];
            wsp_d    = (next_state == S_ADD) && next_step[WRITE_STEP] && !next_mode;
            whl_d    = (next_state == S_ADD) && next_step[WRITE_STEP] && next_mode;
            fw_d     = (next_state == S_ADD) && next_step[WRITE_STEP];
            irf_d    = ((next_state == S_ADD) && next_mode) || (next_state == S_FETCH);
            done_d   = irf_d && next_step[STEPS-1];
        end
    end

    // Sequencer state and registered control outputs
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q       <= S_IDLE;
            step_q        <= '0;
            mode_q        <= 1'b0;
            o_Busy        <= 1'b0;
            o_Cycle       <= 4'b0000;
            o_Address_Out <= 1'b0;
            o_Inc_PC      <= 1'b0;
            o_Bus_In      <= 1'b0;
            o_Write_SP    <= 1'b0;
            o_Write_HL    <= 1'b0;
            o_Flag_Write  <= 1'b0;
            o_IR_Fetch    <= 1'b0;
            o_Done        <= 1'b0;
        end else begin
            state_q       <= next_state;
            step_q        <= next_step;
            mode_q        <= next_mode;
            o_Busy        <= busy_d;
            o_Cycle       <= cycle_d;
            o_Address_Out <= addr_d;
            o_Inc_PC      <= addr_d;
            o_Bus_In      <= bus_in_d;
            o_Write_SP    <= wsp_d;
            o_Write_HL    <= whl_d;
            o_Flag_Write  <= fw_d;
            o_IR_Fetch    <= irf_d;
            o_Done        <= done_d;
        end
    end

    logic [SP_W-1:0] sum_c;
    logic [4:0]      nib_c;
    logic [8:0]      byte_c;
    logic            capture_c;

    assign sum_c     = i_SP + {{EXT_W{imm_q[7]}}, imm_q};
    assign nib_c     = {1'b0, i_SP[3:0]} + {1'b0, imm_q[3:0]};
    assign byte_c    = {1'b0, i_SP[7:0]} + {1'b0, imm_q};
    assign capture_c = (state_q == S_ADD) && step_q[0] && !hold_c;

    // Immediate latch and result/flag registers
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            imm_q    <= 8'h00;
            o_Result <= '0;
            o_Flags  <= 4'b0000;
        end else begin
            if (o_Bus_In) begin
                imm_q <= i_Data;
            end
            if (capture_c) begin
                o_Result <= sum_c;
                o_Flags  <= {2'b00, nib_c[4], byte_c[8]};
            end
        end
    end

endmodule
